// File: rtl/updn_cnt_pkg.sv
// ----------------------------------------------------------------------------
// updn_cnt_pkg
//
// Shared constants and parameter sanity helpers for the up/down counter
// family.
//
// Contents:
//   MODE_WRAP / MODE_SAT : encodings of the sat_mode input
//   DIR_DOWN  / DIR_UP   : encodings of the updn input
//   width_ok()           : WIDTH inside the supported 2..32 range
//   max_val_ok()         : MAX_VAL inside 1..2**WIDTH-1
//   rst_val_ok()         : RST_VAL not above MAX_VAL
//
// The helpers are pure constant functions.  The top module calls them from
// generate blocks so that an illegal parameter set stops elaboration.
// ----------------------------------------------------------------------------
package updn_cnt_pkg;

    // Boundary behaviour selected by sat_mode.
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Count direction selected by updn.
    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // Supported counter widths.
    localparam int unsigned MIN_WIDTH = 2;
    localparam int unsigned MAX_WIDTH = 32;

    // True when the counter width is one the datapath is written for.
    function automatic bit width_ok(input int unsigned w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

    // True when the highest count fits in w bits and leaves a modulus of
    // at least two.  The 64-bit arithmetic keeps WIDTH = 32 from overflowing.
    function automatic bit max_val_ok(input int unsigned w,
                                      input longint unsigned m);
        return (m >= 64'd1) && (m <= ((64'd1 << w) - 64'd1));
    endfunction

    // True when the reset value is a reachable count.
    function automatic bit rst_val_ok(input longint unsigned m,
                                      input longint unsigned r);
        return r <= m;
    endfunction

endpackage : updn_cnt_pkg

// File: rtl/updn_cnt_flag.sv
// ----------------------------------------------------------------------------
// updn_cnt_flag
//
// One sticky event flag.  The flag sets whenever set_i is high on a rising
// clock edge and stays set until clr_i clears it.  When set_i and clr_i are
// both high on the same edge the set wins, so an event is never lost to a
// coincident clear.  Reset is synchronous and active-high.
//
// Ports:
//   clk    in  rising-edge clock
//   rst    in  synchronous active-high reset, forces the flag to 0
//   set_i  in  event to capture
//   clr_i  in  clear request (lower priority than set_i)
//   flag_o out registered sticky flag
// ----------------------------------------------------------------------------
module updn_cnt_flag
    import updn_cnt_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic set_i,
    input  logic clr_i,
    output logic flag_o
);

    logic flag_q;
    logic flag_d;

    // Clear is applied first so that a simultaneous set overrides it.
    always_comb begin
        flag_d = flag_q;
        if (clr_i) begin
            flag_d = 1'b0;
        end
        if (set_i) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign flag_o = flag_q;

endmodule : updn_cnt_flag

// File: rtl/updown_counter_mod.sv
// ----------------------------------------------------------------------------
// updown_counter_mod
//
// Modulo-(MAX_VAL+1) up/down counter with synchronous load, count enable and
// a run-time choice between wrapping and saturating at the boundaries.  Used
// as the common counter primitive for timers, pointers and event counters.
//
// Parameters:
//   WIDTH   counter width, 2..32
//   MAX_VAL highest count value, 1..2**WIDTH-1
//   RST_VAL count loaded by reset, must not exceed MAX_VAL
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   en        in   count enable
//   updn      in   direction, 1 = up, 0 = down
//   load      in   synchronous load strobe (beats en)
//   load_val  in   value to load, clamped to MAX_VAL
//   sat_mode  in   1 = saturate at the boundaries, 0 = wrap
//   count     out  registered count
//   tc        out  combinational terminal count (step about to cross)
//   ovf       out  registered pulse after an up-step taken at MAX_VAL
//   udf       out  registered pulse after a down-step taken at 0
//
// Optional build macro UPDN_CNT_STICKY_EN adds:
//   flag_clr   in   clears both sticky flags (a coincident event wins)
//   sticky_ovf out  set by any overflow event, held until cleared
//   sticky_udf out  set by any underflow event, held until cleared
//
// Edge priority is rst > load > en > hold.
// ----------------------------------------------------------------------------
module updown_counter_mod
    import updn_cnt_pkg::*;
#(
    parameter int unsigned     WIDTH   = 8,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned RST_VAL = 64'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             updn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat_mode,
`ifdef UPDN_CNT_STICKY_EN
    input  logic             flag_clr,
    output logic             sticky_ovf,
    output logic             sticky_udf,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             udf
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("updown_counter_mod: WIDTH must be in 2..32");
    end
    if (!max_val_ok(WIDTH, MAX_VAL)) begin : g_bad_max_val
        $error("updown_counter_mod: MAX_VAL must be in 1..2**WIDTH-1");
    end
    if (!rst_val_ok(MAX_VAL, RST_VAL)) begin : g_bad_rst_val
        $error("updown_counter_mod: RST_VAL must not exceed MAX_VAL");
    end

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_C = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             udf_q;
    logic             udf_d;

    logic at_max;
    logic at_zero;

    assign at_max  = (count_q == MAX_C);
    assign at_zero = (count_q == '0);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // Boundary steps are detected on the current count rather than by
    // letting the adder roll over, so the modulus is MAX_VAL+1 even when
    // MAX_VAL is not all ones.  The event pulses are raised for every step
    // taken at a boundary, whether the count wraps or saturates.
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;

        if (load) begin
            count_d = (load_val > MAX_C) ? MAX_C : load_val;
        end else if (en) begin
            if (updn == DIR_UP) begin
                if (at_max) begin
                    ovf_d   = 1'b1;
                    count_d = (sat_mode == MODE_SAT) ? MAX_C : '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (at_zero) begin
                    udf_d   = 1'b1;
                    count_d = (sat_mode == MODE_SAT) ? '0 : MAX_C;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RST_C;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

    // Terminal count looks ahead: it is high in the cycle whose edge will
    // take a boundary step, in either boundary mode.
    assign tc = en & ~load & ((updn & at_max) | (~updn & at_zero));

    // ------------------------------------------------------------------------
    // Optional sticky event flags
    // ------------------------------------------------------------------------
    // The flags capture the step events themselves (ovf_d / udf_d), so a
    // sticky flag rises in the same cycle as its pulse and a flag_clr that
    // lands on the same edge as a new event cannot erase it.
`ifdef UPDN_CNT_STICKY_EN
    updn_cnt_flag u_sticky_ovf (
        .clk    (clk),
        .rst    (rst),
        .set_i  (ovf_d),
        .clr_i  (flag_clr),
        .flag_o (sticky_ovf)
    );

    updn_cnt_flag u_sticky_udf (
        .clk    (clk),
        .rst    (rst),
        .set_i  (udf_d),
        .clr_i  (flag_clr),
        .flag_o (sticky_udf)
    );
`endif

endmodule : updown_counter_mod

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
- Parametrised successor to the basic up/down counter: modulo-N up/down counter with synchronous load, count enable, and run-time wrap/saturate mode.
- Provides a terminal-count indication and registered overflow/underflow event pulses.
- Serves as the general counter primitive for timers, pointer generators and event counters in the design.

Parameters:
- WIDTH, 8, counter width in bits; legal range 2..32.
- MAX_VAL, 2**WIDTH-1, highest count value (modulus is MAX_VAL+1); legal range 1..2**WIDTH-1.
- RST_VAL, 0, count value loaded on reset; must satisfy RST_VAL <= MAX_VAL.

Ports:
- clk  input  1  clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; step taken only when high.
- updn  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value to load.
- sat_mode  input  1  boundary mode: 1 = saturate, 0 = wrap.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational.
- ovf  output  1  overflow pulse, registered.
- udf  output  1  underflow pulse, registered.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst): applied on the rising clk edge while rst = 1.
- Reset values: count = RST_VAL, ovf = 0, udf = 0.
- Priority on each rising edge: rst > load > en > hold.
- Load:
  - If load_val <= MAX_VAL, count <= load_val; otherwise count <= MAX_VAL (clamped).
  - Load suppresses any step in the same cycle.
  - ovf and udf are 0 in the cycle after a load.
- Step (en = 1, load = 0):
  - Up, count < MAX_VAL: count + 1.
  - Down, count > 0: count - 1.
  - Up at MAX_VAL: 0 if sat_mode = 0; hold MAX_VAL if sat_mode = 1.
  - Down at 0: MAX_VAL if sat_mode = 0; hold 0 if sat_mode = 1.
- Hold: en = 0 and load = 0 keeps count unchanged; ovf and udf are 0 next cycle.
- Arithmetic: modulo MAX_VAL+1, never modulo 2**WIDTH, unless MAX_VAL = 2**WIDTH-1. Count never exceeds MAX_VAL.
- tc = en & ~load & ((updn & count == MAX_VAL) | (~updn & count == 0)).
  - Purely combinational from current inputs and count.
  - Asserts in both modes.
- ovf: 1 for exactly one cycle after an enabled up-step taken at MAX_VAL (wrap or saturate).
- udf: 1 for exactly one cycle after an enabled down-step taken at 0.
- ovf and udf are never both 1.
- Latency: count updates 1 cycle after the controlling inputs are sampled; ovf/udf align with the post-step count.
- Mid-operation changes:
  - Direction or mode changes take effect on the next edge; no state is retained from the previous direction.
  - Reset mid-count returns to RST_VAL regardless of load or en.
- MAX_VAL = 1 degenerate case: count toggles 0/1 when wrapping in either direction.

Optional Feature:
- Macro: UPDN_CNT_STICKY_EN.
- Defined:
  - Adds input flag_clr (1 bit) and outputs sticky_ovf and sticky_udf (1 bit each).
  - Each sticky flag sets on any cycle its pulse flag is set, and holds until flag_clr = 1 or rst.
  - If a set event and flag_clr occur on the same edge, set wins.
  - Reset value of both flags is 0.
- Undefined: those ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package updn_cnt_pkg:
  - Mode constants MODE_WRAP = 1'b0, MODE_SAT = 1'b1.
  - Direction constants DIR_DOWN = 1'b0, DIR_UP = 1'b1.
  - Elaboration-time parameter legality checks.
- Sub-module updn_cnt_flag:
  - One generic set/clear sticky-flag register (set-priority, synchronous reset).
  - Instantiated twice under UPDN_CNT_STICKY_EN.
- Next-value logic stays inline in the top module.

Test Plan (WIDTH = 4, MAX_VAL = 9, RST_VAL = 0 unless stated):
- Reset then up-count, wrap mode: rst 1 cycle, en = 1, updn = 1 for 12 cycles -> count 1..9, 0, 1, 2; tc high while count = 9; ovf high exactly in the cycle count = 0.
- Down-count through zero, wrap mode: load 2, then updn = 0 -> count 2, 1, 0, 9, 8; udf pulses with count = 9.
- Saturate mode: sat_mode = 1, up from 8 -> 9, 9, 9 with ovf high on the 2nd and 3rd cycles. Then down from 1 -> 0, 0 with udf high on the second 0.
- Load priority and clamp:
  - load = 1 with load_val = 13 and en = 1 -> count = 9 next cycle, no ovf.
  - load_val = 5 -> count = 5.
- Reset mid-count with load asserted: count = 7, rst = 1, load = 1, load_val = 3 -> count = RST_VAL (0); ovf = udf = 0.
- UPDN_CNT_STICKY_EN: wrap once -> sticky_ovf = 1 and stays 1. Assert flag_clr coincident with a second wrap -> sticky_ovf stays 1. flag_clr alone -> 0.
